// File: rtl/serial_frame_tx_pkg.sv
// Shared state encoding, default field widths and request validation for the serial frame transmitter.
// No logic of its own: the receiver imports the same widths, so the field layout cannot drift between the two ends.
package serial_frame_tx_pkg;

    localparam int unsigned DEF_PORT_W = 2;
    localparam int unsigned DEF_LEN_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_START = 3'd2,
        S_PORT  = 3'd3,
        S_LEN   = 3'd4,
        S_DATA  = 3'd5,
        S_GAP   = 3'd6
    } tx_state_e;

    // A frame must carry at least one data bit and no more than the payload register holds.
    function automatic logic len_ok(input int unsigned len, input int unsigned data_w);
        return (len >= 1) && (len <= data_w);
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Request/response bundle between a frame requester and the transmitter, plus the serial line itself.
// The requester holds start until it sees ready; reject and frameDone are single-cycle pulses.
interface serial_frame_tx_if
    import serial_frame_tx_pkg::*;
#(
    parameter int unsigned PORT_W = DEF_PORT_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned DATA_W = 15
);
    logic              start;
    logic [PORT_W-1:0] port_num;
    logic [LEN_W-1:0]  data_len;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              reject;
    logic              serOut;
    logic              frameDone;

    modport master (
        output start, port_num, data_len, data_in,
        input  ready, reject, serOut, frameDone
    );

    modport slave (
        input  start, port_num, data_len, data_in,
        output ready, reject, serOut, frameDone
    );
endinterface

// File: rtl/serial_frame_tx_bit_down_counter.sv
// Loadable down-counter shared by the PORT, LEN, DATA and GAP phases; load wins over decrement, stops at zero.
// One-cycle update; o_cnt_nxt exposes the value the register takes at the next edge so the line bit can be registered.
module bit_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_cnt_nxt,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_comb begin
        o_cnt_nxt = r_cnt;
        if (i_load) begin
            o_cnt_nxt = i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            o_cnt_nxt = r_cnt - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_cnt_nxt;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serialises {start 0, port, length, N data bits, idle gap} onto serOut, one bit per clkEn tick, all outputs registered.
// Accepts a request only while ready (IDLE); start while busy is ignored, invalid lengths pulse reject.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int unsigned PORT_W    = DEF_PORT_W,
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned DATA_W    = 15,
    parameter int unsigned IDLE_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clkEn,
    serial_frame_tx_if.slave bus
);

    localparam int unsigned EXT_W = 2 ** LEN_W;

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic [PORT_W-1:0] r_port_sh;
    logic [LEN_W-1:0]  r_len_sh;
    logic [DATA_W-1:0] r_data_sh;
    logic              r_ser_out;
    logic              r_reject;
    logic              r_frame_done;

    logic              w_req_ok;
    logic              w_accept;
    logic              w_bad_req;
    logic              w_done;
    logic              w_load;
    logic [LEN_W-1:0]  w_load_val;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic              w_zero;
    logic              w_ser_nxt;

    // Zero-extended views so the counter value indexes every field without range checks.
    logic [EXT_W-1:0]  w_port_ext;
    logic [EXT_W-1:0]  w_len_ext;
    logic [EXT_W-1:0]  w_data_ext;

    assign w_port_ext = EXT_W'(r_port_sh);
    assign w_len_ext  = EXT_W'(r_len_sh);
    assign w_data_ext = EXT_W'(r_data_sh);

    assign w_req_ok = len_ok(32'(bus.data_len), DATA_W);

    bit_down_counter #(
        .W (LEN_W)
    ) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       (clkEn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_cnt_nxt  (w_cnt_nxt),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_accept    = 1'b0;
        w_bad_req   = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Acceptance does not wait for a tick; ARM then lines the start bit up with one.
                if (bus.start) begin
                    if (w_req_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_ARM;
                    end else begin
                        w_bad_req = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (clkEn) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (clkEn) begin
                    w_state_nxt = S_PORT;
                    w_load      = 1'b1;
                    w_load_val  = LEN_W'(PORT_W - 1);
                end
            end
            S_PORT: begin
                if (clkEn && w_zero) begin
                    w_state_nxt = S_LEN;
                    w_load      = 1'b1;
                    w_load_val  = LEN_W'(LEN_W - 1);
                end
            end
            S_LEN: begin
                if (clkEn && w_zero) begin
                    w_state_nxt = S_DATA;
                    w_load      = 1'b1;
                    w_load_val  = r_len_sh - LEN_W'(1);
                end
            end
            S_DATA: begin
                if (clkEn && w_zero) begin
                    w_state_nxt = S_GAP;
                    w_load      = 1'b1;
                    w_load_val  = LEN_W'(IDLE_BITS - 1);
                end
            end
            S_GAP: begin
                if (clkEn && w_zero) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line value for the state/count the registers are about to take, so serOut moves with them.
    always_comb begin
        w_ser_nxt = 1'b1;
        unique case (w_state_nxt)
            S_START: w_ser_nxt = 1'b0;
            S_PORT:  w_ser_nxt = w_port_ext[w_cnt_nxt];
            S_LEN:   w_ser_nxt = w_len_ext[w_cnt_nxt];
            S_DATA:  w_ser_nxt = w_data_ext[w_cnt_nxt];
            default: w_ser_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_port_sh    <= '0;
            r_len_sh     <= '0;
            r_data_sh    <= '0;
            r_ser_out    <= 1'b1;
            r_reject     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ser_out    <= w_ser_nxt;
            r_reject     <= w_bad_req;
            r_frame_done <= w_done;
            if (w_accept) begin
                r_port_sh <= bus.port_num;
                r_len_sh  <= bus.data_len;
                r_data_sh <= bus.data_in;
            end
        end
    end

    assign bus.ready     = (r_state == S_IDLE);
    assign bus.reject    = r_reject;
    assign bus.serOut    = r_ser_out;
    assign bus.frameDone = r_frame_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed and randomised frames checked cycle by cycle against a bit-list model of the line.
module tb_serial_frame_tx;

    localparam int PW = 2;
    localparam int LW = 4;
    localparam int DW = 8;
    localparam int IB = 2;

    logic clk = 1'b0;
    logic rst;
    logic clkEn;

    int checks   = 0;
    int failures = 0;
    int en_period = 1;
    int en_phase  = 0;
    int en_rand   = 0;
    int stall     = 0;

    always #5 clk = ~clk;

    serial_frame_tx_if #(.PORT_W(PW), .LEN_W(LW), .DATA_W(DW)) bus ();

    serial_frame_tx #(
        .PORT_W    (PW),
        .LEN_W     (LW),
        .DATA_W    (DW),
        .IDLE_BITS (IB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clkEn (clkEn),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then stable and clkEn is chosen for the next edge.
    task automatic cyc();
        @(negedge clk);
        if (stall > 0) begin
            clkEn = 1'b0;
            stall--;
        end else if (en_rand != 0) begin
            clkEn = ($urandom_range(0, 2) == 0);
        end else begin
            en_phase = (en_phase + 1) % en_period;
            clkEn    = (en_phase == 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cyc();
            chk("idle_ser", bus.serOut, 1);
            chk("idle_rdy", bus.ready, 1);
            chk("idle_done", bus.frameDone, 0);
            chk("idle_rej", bus.reject, 0);
        end
    endtask

    task automatic bad_req(input logic [LW-1:0] n);
        chk("bad_pre_rdy", bus.ready, 1);
        bus.start    = 1'b1;
        bus.data_len = n;
        bus.port_num = PW'($urandom);
        bus.data_in  = DW'($urandom);
        cyc();
        bus.start = 1'b0;
        chk("bad_rej", bus.reject, 1);
        chk("bad_rdy", bus.ready, 1);
        chk("bad_ser", bus.serOut, 1);
        cyc();
        chk("bad_rej_clr", bus.reject, 0);
        chk("bad_rdy2", bus.ready, 1);
        chk("bad_ser2", bus.serOut, 1);
    endtask

    // t counts clkEn edges since the accept edge: t=0 is the ARM tick, t=k shows bit k-1 of the frame,
    // and after edge nbits+1 the frame is over.
    task automatic run_frame(input logic [PW-1:0] p, input logic [LW-1:0] n, input logic [DW-1:0] d,
                             input int abort_at, input int freeze_at, input bit poke);
        logic q[$];
        logic exp;
        int   nbits;
        int   t;
        int   tn;
        int   guard;
        int   pk;
        bit   frozen;
        q = {};
        q.push_back(1'b0);
        for (int i = PW - 1; i >= 0; i--) q.push_back(p[i]);
        for (int i = LW - 1; i >= 0; i--) q.push_back(n[i]);
        for (int i = int'(n) - 1; i >= 0; i--) q.push_back(d[i]);
        repeat (IB) q.push_back(1'b1);
        nbits  = q.size();
        pk     = 2 + PW + LW;
        frozen = 1'b0;

        guard = 0;
        while (bus.ready !== 1'b1 && guard < 200) begin
            cyc();
            guard++;
        end
        chk("ready_before_req", bus.ready, 1);
        bus.start    = 1'b1;
        bus.port_num = p;
        bus.data_len = n;
        bus.data_in  = d;
        cyc();
        bus.start    = 1'b0;
        bus.port_num = PW'($urandom);
        bus.data_len = LW'($urandom);
        bus.data_in  = DW'($urandom);

        t = 0;
        guard = 0;
        while (t <= nbits) begin
            exp = (t == 0) ? 1'b1 : q[t-1];
            chk("ser", bus.serOut, exp);
            chk("busy_rdy", bus.ready, 0);
            chk("done_early", bus.frameDone, 0);
            chk("rej_busy", bus.reject, 0);
            if (t == abort_at) begin
                bus.start = 1'b0;
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                chk("abort_ser", bus.serOut, 1);
                chk("abort_rdy", bus.ready, 1);
                chk("abort_done", bus.frameDone, 0);
                return;
            end
            if (t == freeze_at && !frozen) begin
                stall  = 20;
                frozen = 1'b1;
            end
            bus.start = poke && (t == pk);
            tn = clkEn ? t + 1 : t;
            cyc();
            t = tn;
            guard++;
            if (guard > 3000) begin
                chk("frame_timeout", t, nbits + 1);
                bus.start = 1'b0;
                return;
            end
        end
        bus.start = 1'b0;
        chk("done_pulse", bus.frameDone, 1);
        chk("ready_back", bus.ready, 1);
        chk("ser_after", bus.serOut, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [LW-1:0] rn;
        rst          = 1'b1;
        clkEn        = 1'b0;
        bus.start    = 1'b0;
        bus.port_num = '0;
        bus.data_len = '0;
        bus.data_in  = '0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_ser", bus.serOut, 1);
        chk("rst_rdy", bus.ready, 1);
        chk("rst_rej", bus.reject, 0);
        chk("rst_done", bus.frameDone, 0);
        idle(2);

        en_period = 1;
        run_frame(2'b10, 4'd3, 8'b0000_0101, -1, -1, 1'b0);
        idle(3);

        en_period = 4;
        run_frame(2'b10, 4'd3, 8'b0000_0101, -1, -1, 1'b0);
        idle(2);

        bad_req(4'd0);
        bad_req(4'd15);
        bad_req(LW'(DW + 1));
        idle(1);

        en_period = 1;
        run_frame(2'b01, 4'd8, 8'hA5, -1, -1, 1'b1);
        run_frame(2'b11, 4'd5, 8'h3C, -1, -1, 1'b0);
        run_frame(2'b00, 4'd1, 8'h01, -1, -1, 1'b0);
        idle(2);

        en_period = 2;
        run_frame(2'b10, 4'd6, 8'h5A, 3 + PW, -1, 1'b0);
        idle(2);
        run_frame(2'b01, 4'd4, 8'h09, -1, -1, 1'b0);
        run_frame(2'b11, 4'd7, 8'h6E, -1, 5, 1'b0);
        idle(2);

        en_rand = 1;
        for (int k = 0; k < 25; k++) begin
            rn = LW'($urandom_range(1, DW));
            run_frame(PW'($urandom), rn, DW'($urandom), -1,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1,
                      ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
                bad_req(($urandom_range(0, 1) == 0) ? 4'd0 : LW'($urandom_range(DW + 1, 15)));
            end
        end
        en_rand = 0;
        en_period = 1;
        idle(1);

        run_frame(2'b11, 4'd1, 8'h01, -1, -1, 1'b0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Upstream frame generator for the serial port-demux receiver controller. It drives that receiver's serIn line.
- Accepts a parallel request (destination port, data length, data word) and serializes it onto one line.
- Frame format is the one the receiver decodes: start bit 0, port field, length field, then exactly N data bits, then a mandatory idle gap.
- Timing is paced by the shared clkEn tick, so transmitter and receiver advance in lockstep.

Parameters:
- PORT_W, 2, width of the port field; the receiver's co1 counter spans PORT_W bits.
- LEN_W, 4, width of the length field; the receiver's co2 counter spans LEN_W bits.
- DATA_W, 15, data register width; must be at most 2**LEN_W-1.
- IDLE_BITS, 1, number of idle (1) bit periods after the last data bit; must be at least 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- clkEn  in  1  bit-rate tick; all line timing advances only on cycles with clkEn=1.
- start  in  1  request strobe; sampled every clk cycle.
- port_num  in  PORT_W  destination port; sent MSB first.
- data_len  in  LEN_W  number of data bits N; sent MSB first.
- data_in  in  DATA_W  payload; bits data_in[N-1] down to data_in[0] are sent.
- ready  out  1  high only in IDLE; a request is accepted only while ready=1.
- reject  out  1  one-cycle pulse when start arrives in IDLE with N=0 or N>DATA_W.
- serOut  out  1  serial line; idles at 1; connects to the receiver's serIn.
- frameDone  out  1  one-cycle pulse when the frame, including the gap, completes.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high, and rst has priority over start and clkEn.
- Reset values: state=IDLE, serOut=1, ready=1, reject=0, frameDone=0, counters and shadow registers cleared.
- Accepting a request:
  - Accept occurs when ready=1, start=1 and 1<=data_len<=DATA_W. clkEn is not required.
  - On accept, port_num, data_len and data_in are latched into shadow registers, state goes to ARM, and ready=0 from the next cycle.
  - Inputs may change after the accept cycle.
- Invalid length: when ready=1, start=1 and data_len is 0 or greater than DATA_W, the block pulses reject for one cycle, stays in IDLE and leaves serOut at 1.
- start while ready=0 is ignored, with no reject pulse.
- State machine (every transition below happens only on a cycle with clkEn=1; otherwise state holds):
  - IDLE: serOut=1.
  - ARM: serOut=1. Next state START. This aligns the start bit to a clkEn boundary.
  - START: serOut=0 for one tick. Next state PORT; bit counter loads PORT_W-1.
  - PORT: serOut=port_sh[cnt]. Next state LEN when cnt==0; counter loads LEN_W-1.
  - LEN: serOut=len_sh[cnt]. Next state DATA when cnt==0; counter loads N-1.
  - DATA: serOut=data_sh[cnt]. Next state GAP when cnt==0; counter loads IDLE_BITS-1.
  - GAP: serOut=1. Next state IDLE when cnt==0.
- frameDone: pulses on the clk cycle following the clkEn edge that leaves GAP. ready rises in that same cycle.
- Bit timing:
  - Every bit lasts exactly one clkEn period.
  - serOut is registered and changes only in the cycle after a clkEn=1 edge, so there are no glitches.
  - Total frame length is 1+PORT_W+LEN_W+N+IDLE_BITS ticks after ARM.
- Back-to-back frames: start asserted in the same cycle ready rises is accepted. The gap guarantees the receiver has returned to its idle state and seen serOut=1 before the next start bit.
- clkEn stuck at 0: the FSM freezes and serOut holds its current value indefinitely.
- Reset mid-frame: serOut returns to 1 the next cycle with no frameDone pulse. The system resets the receiver on the same rst.

Decomposition:
- Shared header frame_defs.vh holds:
  - the state encodings IDLE, ARM, START, PORT, LEN, DATA and GAP (3 bits);
  - the default PORT_W and LEN_W values, shared with the receiver so field widths cannot drift.
- One sub-module, bit_down_counter:
  - loadable LEN_W-wide down-counter with enable (clkEn);
  - outputs cnt and zero flag;
  - reused for the PORT, LEN, DATA and GAP phases.
- Bit select is done by indexing the shadow registers with cnt; no shifting of the shadow registers.

Test Plan:
- Basic frame, clkEn every cycle: port_num=2'b10, data_len=3, data_in=...101 -> serOut after ARM is 0,1,0,0,0,1,1,1,0,1,1 (11 ticks); frameDone pulses once; ready low from the accept cycle+1 until frameDone.
- Sparse tick, clkEn every 4th cycle: same request -> each bit held for exactly 4 clk cycles; serOut changes only after clkEn edges; total 44 cycles from START to IDLE.
- Invalid length: data_len=0 and data_len=15 with DATA_W=8 -> reject pulses one cycle; serOut stays 1; ready stays 1.
- Busy and back-to-back:
  - start during DATA is ignored;
  - start held across frameDone is accepted in that cycle -> second frame begins;
  - line shows exactly IDLE_BITS ones between frames.
- Reset mid-frame: rst asserted during the LEN phase -> serOut=1 and ready=1 the next cycle; no frameDone; a following request transmits correctly.
- Loopback with the receiver controller: port 3, N=1 -> receiver takes its short path from load straight back to idle; serOutValid high for 1 tick; receiver Done returns high.
